// File: rtl/hist_pkg.sv
// Shared constants and types for the histogram core and its readout capture.
// Both ends import these so producer and consumer agree on frame geometry.
package hist_pkg;

    localparam int NUM_BINS = 16;
    localparam int DATA_W   = 8;
    localparam int IDX_W    = $clog2(NUM_BINS);
    localparam int SUM_W    = DATA_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/hist_bin_ram.sv
// Single-write, single-registered-read bin buffer with read-before-write.
// Only the read register is reset; the array itself is never cleared.
module hist_bin_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Separate read register: same-cycle read of the written address sees the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/hist_stream_capture.sv
// Captures one histogram readout frame into a local buffer and derives
// total, peak value/index and a length-error flag from the stream.
module hist_stream_capture
    import hist_pkg::*;
#(
    parameter int NUM_BINS = hist_pkg::NUM_BINS,
    parameter int DATA_W   = hist_pkg::DATA_W,
    parameter int IDX_W    = hist_pkg::IDX_W,
    parameter int SUM_W    = hist_pkg::SUM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              last_in,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [IDX_W:0]    bin_count,
    output logic [SUM_W-1:0]  sum_out,
    output logic [DATA_W-1:0] peak_val,
    output logic [IDX_W-1:0]  peak_idx,
    output logic              err_len
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BINS);

    cap_state_t        state_q,    state_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [SUM_W-1:0]  sum_q,      sum_d;
    logic [DATA_W-1:0] peak_val_q, peak_val_d;
    logic [IDX_W-1:0]  peak_idx_q, peak_idx_d;
    logic              err_q,      err_d;

    logic              wr_en;
    logic              overflow;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sum_d      = sum_q;
        peak_val_d = peak_val_q;
        peak_idx_d = peak_idx_q;
        err_d      = err_q;
        wr_en      = 1'b0;
        overflow   = 1'b0;

        // arm takes priority in every state, including over a same-cycle beat.
        if (arm) begin
            state_d    = CAPTURE;
            count_d    = '0;
            sum_d      = '0;
            peak_val_d = '0;
            peak_idx_d = '0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                CAPTURE: begin
                    if (valid_in) begin
                        if (count_q != FULL_CNT) begin
                            wr_en   = 1'b1;
                            count_d = count_q + 1'b1;
                            sum_d   = sum_q + {{IDX_W{1'b0}}, data_in};
                            if (data_in > peak_val_q) begin
                                peak_val_d = data_in;
                                peak_idx_d = count_q[IDX_W-1:0];
                            end
                        end else begin
                            overflow = 1'b1;
                            err_d    = 1'b1;
                        end
                        if (last_in) begin
                            state_d = DONE;
                            if ((count_d != FULL_CNT) || overflow) begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            sum_q      <= '0;
            peak_val_q <= '0;
            peak_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            peak_val_q <= peak_val_d;
            peak_idx_q <= peak_idx_d;
            err_q      <= err_d;
        end
    end

    hist_bin_ram #(
        .DEPTH  (NUM_BINS),
        .DATA_W (DATA_W),
        .ADDR_W (IDX_W)
    ) u_bin_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_en && !reset),
        .wr_addr (count_q[IDX_W-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign busy      = (state_q == CAPTURE);
    assign done      = (state_q == DONE);
    assign bin_count = count_q;
    assign sum_out   = sum_q;
    assign peak_val  = peak_val_q;
    assign peak_idx  = peak_idx_q;
    assign err_len   = err_q;

endmodule

// File: tb/tb_hist_stream_capture.sv
// Directed and randomized frames against a queue-based reference of the
// capture rules; every comparison is an immediate assertion.
module tb_hist_stream_capture;
    import hist_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                arm;
    logic                valid_in;
    logic [DATA_W-1:0]   data_in;
    logic                last_in;
    logic [IDX_W-1:0]    rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic                busy;
    logic                done;
    logic [IDX_W:0]      bin_count;
    logic [SUM_W-1:0]    sum_out;
    logic [DATA_W-1:0]   peak_val;
    logic [IDX_W-1:0]    peak_idx;
    logic                err_len;

    int total = 0;
    int bad   = 0;

    // Reference: 0 idle, 1 capture, 2 done; frame_q holds every beat accepted while capturing.
    int          model_state = 0;
    logic [7:0]  frame_q[$];
    logic [7:0]  stim_q[$];
    logic [7:0]  mem_model[NUM_BINS];
    bit          mem_known[NUM_BINS];

    hist_stream_capture dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .bin_count (bin_count),
        .sum_out   (sum_out),
        .peak_val  (peak_val),
        .peak_idx  (peak_idx),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        int n, cnt, sum, pv, pi, err;
        n   = frame_q.size();
        cnt = (n < NUM_BINS) ? n : NUM_BINS;
        sum = 0;
        pv  = 0;
        pi  = 0;
        for (int i = 0; i < cnt; i++) begin
            sum += int'(frame_q[i]);
            if (int'(frame_q[i]) > pv) begin
                pv = int'(frame_q[i]);
                pi = i;
            end
        end
        if (model_state == 2)      err = (n != NUM_BINS) ? 1 : 0;
        else if (model_state == 1) err = (n > NUM_BINS) ? 1 : 0;
        else                       err = 0;
        check({tag, ".busy"},      32'(busy),      32'((model_state == 1) ? 1 : 0));
        check({tag, ".done"},      32'(done),      32'((model_state == 2) ? 1 : 0));
        check({tag, ".bin_count"}, 32'(bin_count), 32'(cnt));
        check({tag, ".sum_out"},   32'(sum_out),   32'(sum));
        check({tag, ".peak_val"},  32'(peak_val),  32'(pv));
        check({tag, ".peak_idx"},  32'(peak_idx),  32'(pi));
        check({tag, ".err_len"},   32'(err_len),   32'(err));
        $display("txn %s: n=%0d cnt=%0d sum=%0d peak=%0d@%0d err=%0d", tag, n, cnt, sum, pv, pi, err);
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        int         idx;
        logic [7:0] old;
        bit         chk;
        chk = 0;
        old = '0;
        if (model_state == 1 && frame_q.size() < NUM_BINS) begin
            idx     = frame_q.size();
            rd_addr = idx[IDX_W-1:0];
            if (mem_known[idx]) begin
                chk = 1;
                old = mem_model[idx];
            end
        end
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        tick();
        valid_in = 1'b0;
        last_in  = 1'b0;
        data_in  = 8'($urandom);
        if (model_state == 1) begin
            if (frame_q.size() < NUM_BINS) begin
                mem_model[frame_q.size()] = d;
                mem_known[frame_q.size()] = 1'b1;
            end
            frame_q.push_back(d);
            if (l) model_state = 2;
        end
        if (chk) check("read_before_write", 32'(rd_data), 32'(old));
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            data_in = 8'($urandom);
            last_in = 1'($urandom);
            tick();
            last_in = 1'b0;
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        frame_q.delete();
        model_state = 1;
    endtask

    task automatic arm_with_beat(input logic [7:0] d, input logic l);
        arm      = 1'b1;
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        tick();
        arm      = 1'b0;
        valid_in = 1'b0;
        last_in  = 1'b0;
        frame_q.delete();
        model_state = 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        frame_q.delete();
        model_state = 0;
        for (int i = 0; i < NUM_BINS; i++) mem_known[i] = 1'b0;
    endtask

    task automatic send_stim(input bit gaps);
        for (int i = 0; i < stim_q.size(); i++) begin
            if (gaps) gap($urandom_range(0, 2));
            beat(stim_q[i], (i == stim_q.size() - 1));
        end
    endtask

    task automatic check_reads(input string tag);
        for (int i = 0; i < NUM_BINS; i++) begin
            if (mem_known[i]) begin
                rd_addr = i[IDX_W-1:0];
                tick();
                check({tag, ".rd_data"}, 32'(rd_data), 32'(mem_model[i]));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        arm      = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        last_in  = 1'b0;
        rd_addr  = '0;
        for (int i = 0; i < NUM_BINS; i++) mem_known[i] = 1'b0;
        tick();
        tick();
        check("reset.rd_data", 32'(rd_data), 32'h0);
        check_outputs("reset");
        reset = 1'b0;

        // Beats in IDLE must be ignored.
        beat(8'd9, 1'b0);
        beat(8'd7, 1'b1);
        check_outputs("idle_beats");

        // Normal frame: value equals index.
        do_arm();
        stim_q.delete();
        for (int i = 0; i < NUM_BINS; i++) stim_q.push_back(8'(i));
        send_stim(1'b0);
        check_outputs("normal");
        check("normal.sum_const", 32'(sum_out), 32'd120);
        rd_addr = 4'd7;
        tick();
        check("normal.rd7", 32'(rd_data), 32'd7);
        check_reads("normal");

        // Beats and last while DONE are ignored.
        beat(8'd99, 1'b1);
        beat(8'd250, 1'b0);
        check_outputs("done_hold");

        // Gapped stream with a tie at the peak.
        do_arm();
        stim_q.delete();
        for (int i = 0; i < NUM_BINS; i++) stim_q.push_back((i == 5 || i == 9) ? 8'd200 : 8'd3);
        send_stim(1'b1);
        check_outputs("gapped_tie");
        check("gapped_tie.peak_idx_const", 32'(peak_idx), 32'd5);

        // Short frame.
        do_arm();
        stim_q.delete();
        repeat (10) stim_q.push_back(8'd1);
        send_stim(1'b0);
        check_outputs("short");

        // Long frame: overflow flagged before last arrives.
        do_arm();
        for (int i = 0; i < 17; i++) beat(8'd2, 1'b0);
        check_outputs("long_ovf");
        beat(8'd2, 1'b1);
        check_outputs("long");
        check_reads("long");

        // IDLE beats, abort by re-arm, then a full frame of 4s.
        do_reset();
        beat(8'd77, 1'b0);
        beat(8'd78, 1'b1);
        check_outputs("abort_idle");
        do_arm();
        for (int i = 0; i < 5; i++) beat(8'(10 + i), 1'b0);
        check_outputs("abort_partial");
        do_arm();
        stim_q.delete();
        repeat (NUM_BINS) stim_q.push_back(8'd4);
        send_stim(1'b1);
        check_outputs("abort_full");

        // arm together with a last beat discards the frame.
        do_arm();
        for (int i = 0; i < 7; i++) beat(8'(i * 3), 1'b0);
        arm_with_beat(8'd50, 1'b1);
        check_outputs("arm_vs_last");
        stim_q.delete();
        for (int i = 0; i < NUM_BINS; i++) stim_q.push_back(8'(100 - i));
        send_stim(1'b0);
        check_outputs("arm_vs_last_full");

        // Randomized frames of varying length, values and gaps.
        for (int t = 0; t < 25; t++) begin
            int n;
            do_arm();
            n = $urandom_range(1, 20);
            stim_q.delete();
            for (int i = 0; i < n; i++) begin
                stim_q.push_back(($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 15)));
            end
            send_stim(1'($urandom));
            check_outputs($sformatf("rand%0d", t));
            check_reads($sformatf("rand%0d", t));
        end

        // Mid-frame reset clears everything; later beats need a new arm.
        do_arm();
        for (int i = 0; i < 8; i++) beat(8'(i + 20), 1'b0);
        check_outputs("pre_reset");
        do_reset();
        check_outputs("mid_reset");
        beat(8'd5, 1'b0);
        beat(8'd6, 1'b1);
        check_outputs("post_reset_beats");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
